lsu32: RTL
==========

LSU32 -- requirements
Module: lsu32

Interface
REQ-001 Parameter: ADDR_W, default 17, CPU byte-address width (128 KB data memory).
REQ-002 Parameter: WORD_AW, default 15, memory word-address width (ADDR_W-2).
REQ-003 Ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 Ports: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: req_valid  in  1  CPU access request.
REQ-006 Ports: req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-007 Ports: req_we  in  1  1=store, 0=load.
REQ-008 Ports: req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 Ports: req_unsigned  in  1  load zero-extends when high, sign-extends when low.
REQ-010 Ports: req_addr  in  ADDR_W  byte address.
REQ-011 Ports: req_wdata  in  32  store data, right-justified.
REQ-012 Ports: resp_valid  out  1  one-cycle completion pulse.
REQ-013 Ports: resp_rdata  out  32  extended load data, 0 for stores.
REQ-014 Ports: resp_err  out  1  access faulted, valid with resp_valid.
REQ-015 Ports: mem_addr  out  WORD_AW  word address = req_addr[ADDR_W-1:2].
REQ-016 Ports: mem_re, mem_we  out  1 each  registered memory strobes.
REQ-017 Ports: mem_wdata  out  32  full word to write.
REQ-018 Ports: mem_rdata  in  32  word returned one cycle after mem_re.

Function
REQ-019 FSM states IDLE, RD, CAP, WR, RESP; req_ready = (state==IDLE); all request fields captured on acceptance.
REQ-020 Load: accept cycle N -> RD (mem_re=1, N+1) -> CAP (capture mem_rdata, N+2) -> RESP (resp_valid=1, N+3) -> IDLE.
REQ-021 Word store: accept N -> WR (mem_we=1, mem_wdata=req_wdata, N+1) -> RESP (N+2) -> IDLE.
REQ-022 Byte/half store is read-modify-write: accept N -> RD (N+1) -> CAP merge (N+2) -> WR (N+3) -> RESP (N+4); only addressed lanes replaced.
REQ-023 Little-endian lanes: byte lane = addr[1:0] (bits 8*k+7:8*k); half lane = addr[1] (bits 16*h+15:16*h).
REQ-024 Load extension: byte/half sign-extended from bit 7/15 unless req_unsigned; word passed unchanged.
REQ-025 mem_re and mem_we never both high; each high for exactly one cycle per access phase.
REQ-026 resp_valid high exactly one cycle in RESP, no backpressure; next request acceptable the following cycle.
REQ-027 req_valid while not in IDLE is ignored (not queued); request fields may change freely then.
REQ-028 mem_addr holds captured word address from RD through WR.

Reset
REQ-029 On rst: state IDLE; req_ready=1 on the following cycle; resp_valid, resp_err, mem_re, mem_we = 0; resp_rdata, mem_wdata, mem_addr = 0.
REQ-030 Reset mid-operation abandons the access; no mem_we or resp_valid occurs after the reset edge for it.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> IDLE->RESP directly, resp_err=1, resp_rdata=0, no memory strobe, response at N+1.
REQ-032 Macro undefined: resp_err tied 0; half ignores addr[0], word ignores addr[1:0], size=11 treated as word.

Verification
REQ-033 Word store 0xDEADBEEF @0x0100, word load @0x0100 -> mem_we at N+1, resp_valid at N+2; load resp_rdata=0xDEADBEEF at N+3.
REQ-034 Memory word 0x11223344 @0x0200; byte store 0xAA @0x0201 -> mem_wdata=0x1122AA44 at N+3, resp_valid N+4.
REQ-035 Word 0x80FF7F01 @0x0300: signed byte @0x0302 -> 0xFFFFFFFF; unsigned half @0x0302 -> 0x000080FF; signed byte @0x0300 -> 0x00000001.
REQ-036 Half load @0x0301 with LSU_MISALIGN_TRAP_EN -> resp_err=1 at N+1, no mem_re; without macro -> lane 0x0300 data, resp_err=0 at N+3.
REQ-037 rst asserted in CAP of byte store -> no mem_we, no resp_valid, req_ready=1 next cycle, memory word unchanged.
REQ-038 req_valid held high continuously over back-to-back loads -> exactly one acceptance per 4 cycles, req_ready low in RD/CAP/RESP.

Source files
------------

// File: rtl/lsu32.sv
// LSU32: byte/half/word load-store unit over a 32-bit word memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned and reserved-size accesses.
module lsu32 #(
    parameter int ADDR_W  = 17,
    parameter int WORD_AW = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [WORD_AW-1:0] mem_addr,
    output logic               mem_re,
    output logic               mem_we,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state, state_n;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        mis;
    logic        sub_word;
    logic        accept;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign sub_word  = (req_size == 2'b00) | (req_size == 2'b01);
    assign req_ready = (state == IDLE);
    assign accept    = req_ready & req_valid;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (mis)
                        state_n = RESP;
                    else if (!req_we || sub_word)
                        state_n = RD;
                    else
                        state_n = WR;
                end
            end
            RD:      state_n = CAP;
            CAP:     state_n = we_q ? WR : RESP;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for read-modify-write
    always_comb begin
        byte_v   = mem_rdata[{lane_q, 3'b000} +: 8];
        half_v   = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        merged   = mem_rdata;
        unique case (size_q)
            2'b00: begin
                load_ext = {{24{~uns_q & byte_v[7]}}, byte_v};
                merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = {{16{~uns_q & half_v[15]}}, half_v};
                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_ext = mem_rdata;
                merged   = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_wdata  <= '0;
            mem_addr   <= '0;
        end else begin
            state      <= state_n;
            mem_re     <= (state_n == RD);
            mem_we     <= (state_n == WR);
            resp_valid <= (state_n == RESP);
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                uns_q      <= req_unsigned;
                lane_q     <= req_addr[1:0];
                wdata_q    <= req_wdata;
                mem_addr   <= req_addr[ADDR_W-1:2];
                mem_wdata  <= req_wdata;
                resp_err   <= mis;
                resp_rdata <= '0;
            end
            if (state == CAP) begin
                if (we_q)
                    mem_wdata <= merged;
                else
                    resp_rdata <= load_ext;
            end
        end
    end

endmodule
